// File: rtl/syn_pkg.sv
// Shared constants and clamp helpers for the spike synapse and its rate counter.
package syn_pkg;

  localparam int SYN_WIDTH  = 8;
  localparam int RATE_WIDTH = 8;

  // Operands are at most 16 bits wide here, so a 32-bit sum cannot wrap.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned maxv);
    int unsigned sum;
    sum = a + b;
    return (sum > maxv) ? maxv : sum;
  endfunction

  function automatic logic add_clamps(input int unsigned a, input int unsigned b,
                                      input int unsigned maxv);
    return (a + b) > maxv;
  endfunction

  function automatic int unsigned floor_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : 32'd0;
  endfunction

endpackage

// File: rtl/spike_rate_counter.sv
// Counts spikes over a fixed window and publishes the saturated count with a one-cycle valid pulse.
module spike_rate_counter
  import syn_pkg::*;
#(
  parameter int RATE_WINDOW = 256
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spike_in,
  output logic [RATE_WIDTH-1:0] rate,
  output logic                  rate_valid
);

  localparam int          WW       = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;
  localparam int unsigned RATE_MAX = (1 << RATE_WIDTH) - 1;

  logic [WW-1:0]         win_q, win_d;
  logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic                  valid_q, valid_d;
  logic                  last_cycle;
  logic [RATE_WIDTH-1:0] cnt_inc;

  always_comb begin
    last_cycle = (win_q == WW'(RATE_WINDOW - 1));
    cnt_inc    = RATE_WIDTH'(sat_add(32'(cnt_q), 32'(spike_in), RATE_MAX));
    win_d      = win_q + WW'(1);
    cnt_d      = cnt_inc;
    rate_d     = rate_q;
    valid_d    = 1'b0;
    // A spike in the closing cycle belongs to the closing window only.
    if (last_cycle) begin
      win_d   = '0;
      cnt_d   = '0;
      rate_d  = cnt_inc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q   <= '0;
      cnt_q   <= '0;
      rate_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = valid_q;

endmodule

// File: rtl/spike_synapse.sv
// Turns a spike train into a decaying synaptic current trace plus a windowed rate estimate.
// Defining SYN_INHIBIT_EN adds the spike_inh input, which subtracts the weight (floored at 0).
module spike_synapse
  import syn_pkg::*;
#(
  parameter int WIDTH        = SYN_WIDTH,
  parameter int DECAY_PERIOD = 16,
  parameter int DECAY_SHIFT  = 2,
  parameter int RATE_WINDOW  = 256
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spike_in,
`ifdef SYN_INHIBIT_EN
  input  logic                  spike_inh,
`endif
  input  logic [WIDTH-1:0]      weight,
  output logic [WIDTH-1:0]      current,
  output logic [RATE_WIDTH-1:0] rate,
  output logic                  rate_valid,
  output logic                  saturated
);

  localparam int          PW   = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int unsigned MAXV = (1 << WIDTH) - 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] current_q, current_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] shifted, dec, base, add;

  always_comb begin
    tick    = (presc_q == PW'(DECAY_PERIOD - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    shifted = current_q >> DECAY_SHIFT;
    dec     = '0;
    // Force a decay of at least one so small traces still reach zero.
    if (tick) begin
      dec = (current_q != '0 && shifted == '0) ? WIDTH'(1) : shifted;
    end
    base      = current_q - dec;
    add       = spike_in ? weight : '0;
    current_d = WIDTH'(sat_add(32'(base), 32'(add), MAXV));
    sat_d     = add_clamps(32'(base), 32'(add), MAXV);
`ifdef SYN_INHIBIT_EN
    if (spike_inh) begin
      sat_d     = 1'b0;
      current_d = spike_in ? base : WIDTH'(floor_sub(32'(base), 32'(weight)));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      current_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      current_q <= current_d;
      sat_q     <= sat_d;
    end
  end

  spike_rate_counter #(
    .RATE_WINDOW(RATE_WINDOW)
  ) u_rate (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .rate      (rate),
    .rate_valid(rate_valid)
  );

  assign current   = current_q;
  assign saturated = sat_q;

endmodule
